// File: rtl/dma_bus_reader.sv
`default_nettype none
// ============================================================================
//  Module   : dma_bus_reader
//  Purpose  : Bus-master DMA engine that reads a block of 32-bit words from a
//             shared bus in bursts and writes them into a local scratchpad.
//  Revision : 1.0 - initial release
// ============================================================================
module dma_bus_reader #(
    parameter int MEM_ADDR_WIDTH = 9
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               busStartAddress,
    input  logic [MEM_ADDR_WIDTH-1:0] memStartAddress,
    input  logic [9:0]                blockSize,
    input  logic [7:0]                burstSize,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic                      requestTransaction,
    input  logic                      transactionGranted,
    output logic                      beginTransactionOut,
    output logic                      readNotWriteOut,
    output logic [31:0]               addressDataOut,
    output logic [3:0]                byteEnablesOut,
    output logic [7:0]                burstSizeOut,
    input  logic [31:0]               addressDataIn,
    input  logic                      dataValidIn,
    input  logic                      endTransactionIn,
    input  logic                      busErrorIn,
    output logic                      memWriteEnable,
    output logic [MEM_ADDR_WIDTH-1:0] memAddress,
    output logic [31:0]               memWriteData
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQUEST = 3'd1,
        BEGIN   = 3'd2,
        RECEIVE = 3'd3,
        FINISH  = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [31:0]               bus_addr_q, bus_addr_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [9:0]                remaining_q, remaining_d;
    logic [7:0]                burst_q, burst_d;
    logic [9:0]                burst_len_q, burst_len_d;
    logic [9:0]                beats_q, beats_d;
    logic                      error_q, error_d;
    logic                      zero_done_q, zero_done_d;

    // Beats in the next burst: the smaller of what is left and the burst cap.
    logic [9:0] w_burst_plus1;
    logic [9:0] w_burst_len;
    logic       w_beat;
    logic [9:0] w_beats_next;
    logic [9:0] w_rem_next;

    assign w_burst_plus1 = {2'b00, burst_q} + 10'd1;
    assign w_burst_len   = (remaining_q < w_burst_plus1) ? remaining_q : w_burst_plus1;
    // A beat only counts while the current burst still expects data.
    assign w_beat        = dataValidIn && !busErrorIn && (beats_q < burst_len_q);
    assign w_beats_next  = beats_q + {9'd0, w_beat};
    assign w_rem_next    = remaining_q - {9'd0, w_beat};

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bus_addr_q  <= '0;
            mem_addr_q  <= '0;
            remaining_q <= '0;
            burst_q     <= '0;
            burst_len_q <= '0;
            beats_q     <= '0;
            error_q     <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            mem_addr_q  <= mem_addr_d;
            remaining_q <= remaining_d;
            burst_q     <= burst_d;
            burst_len_q <= burst_len_d;
            beats_q     <= beats_d;
            error_q     <= error_d;
            zero_done_q <= zero_done_d;
        end
    end

    // Next-state logic and all outputs; bus outputs idle at zero (OR-combined bus).
    always_comb begin
        state_d             = state_q;
        bus_addr_d          = bus_addr_q;
        mem_addr_d          = mem_addr_q;
        remaining_d         = remaining_q;
        burst_d             = burst_q;
        burst_len_d         = burst_len_q;
        beats_d             = beats_q;
        error_d             = error_q;
        zero_done_d         = 1'b0;
        busy                = 1'b0;
        done                = zero_done_q;
        requestTransaction  = 1'b0;
        beginTransactionOut = 1'b0;
        readNotWriteOut     = 1'b0;
        addressDataOut      = '0;
        byteEnablesOut      = '0;
        burstSizeOut        = '0;
        memWriteEnable      = 1'b0;
        memAddress          = '0;
        memWriteData        = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (blockSize == 10'd0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        bus_addr_d  = {busStartAddress[31:2], 2'b00};
                        mem_addr_d  = memStartAddress;
                        remaining_d = blockSize;
                        burst_d     = burstSize;
                        state_d     = REQUEST;
                    end
                end
            end

            REQUEST: begin
                busy               = 1'b1;
                requestTransaction = 1'b1;
                if (busErrorIn) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end else if (transactionGranted) begin
                    state_d = BEGIN;
                end
            end

            BEGIN: begin
                busy                = 1'b1;
                requestTransaction  = 1'b1;
                beginTransactionOut = 1'b1;
                readNotWriteOut     = 1'b1;
                byteEnablesOut      = 4'hF;
                addressDataOut      = {bus_addr_q[31:2], 2'b00};
                burstSizeOut        = w_burst_len[7:0] - 8'd1;
                burst_len_d         = w_burst_len;
                beats_d             = '0;
                if (busErrorIn) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    state_d = RECEIVE;
                end
            end

            RECEIVE: begin
                busy               = 1'b1;
                requestTransaction = 1'b1;
                if (busErrorIn) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    if (w_beat) begin
                        memWriteEnable = 1'b1;
                        memAddress     = mem_addr_q;
                        memWriteData   = addressDataIn;
                        mem_addr_d     = mem_addr_q + 1'b1;
                    end
                    beats_d     = w_beats_next;
                    remaining_d = w_rem_next;
                    // The beat of this cycle is already included in the end decision.
                    if (endTransactionIn) begin
                        bus_addr_d = bus_addr_q + {20'd0, w_beats_next, 2'b00};
                        state_d    = (w_rem_next != 10'd0) ? REQUEST : FINISH;
                    end
                end
            end

            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign error = error_q;

endmodule
`default_nettype wire

// File: doc/dma_bus_reader.md
DMA_BUS_READER -- requirements
Module: dma_bus_reader

Interface
REQ-001 The block SHALL have parameter MEM_ADDR_WIDTH, default 9: word-address width of the scratchpad write port (512 words).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  one-cycle pulse that launches a transfer.
REQ-006 The block SHALL have port busStartAddress  input  32  byte address of the first source word; bits [1:0] ignored.
REQ-007 The block SHALL have port memStartAddress  input  MEM_ADDR_WIDTH  first scratchpad word address.
REQ-008 The block SHALL have port blockSize  input  10  number of words to move; 0 = no-op.
REQ-009 The block SHALL have port burstSize  input  8  maximum beats per burst minus 1.
REQ-010 The block SHALL have port busy  output  1  transfer in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 The block SHALL have port error  output  1  sticky; last transfer aborted by bus error.
REQ-013 The block SHALL have port requestTransaction  output  1  bus request to arbiter.
REQ-014 The block SHALL have port transactionGranted  input  1  arbiter grant.
REQ-015 The block SHALL have ports beginTransactionOut, readNotWriteOut  output  1 each  bus transaction start and direction.
REQ-016 The block SHALL have port addressDataOut  output  32  bus address.
REQ-017 The block SHALL have port byteEnablesOut  output  4  bus byte enables.
REQ-018 The block SHALL have port burstSizeOut  output  8  bus burst size (beats minus 1).
REQ-019 The block SHALL have ports addressDataIn  input  32, plus dataValidIn, endTransactionIn, busErrorIn  input  1 each  bus read data, beat valid, burst end, bus error.
REQ-020 The block SHALL have ports memWriteEnable  output  1, memAddress  output  MEM_ADDR_WIDTH, memWriteData  output  32  scratchpad write port.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, REQUEST, BEGIN, RECEIVE and FINISH.
REQ-022 In IDLE, start with blockSize=0 SHALL pulse done in the next cycle without asserting busy or requestTransaction.
REQ-023 In IDLE, start with blockSize>0 SHALL latch all configuration inputs, assert busy and go to REQUEST.
REQ-024 start while busy SHALL be ignored.
REQ-025 In REQUEST the block SHALL hold requestTransaction=1 until transactionGranted=1, then go to BEGIN.
REQ-026 In BEGIN, for exactly one cycle, the block SHALL drive beginTransactionOut=1, readNotWriteOut=1, byteEnablesOut=4'hF, addressDataOut={current address[31:2],2'b00} and burstSizeOut=min(remaining,burstSize+1)-1, then go to RECEIVE.
REQ-027 All bus outputs SHALL be 0 in every cycle other than BEGIN (OR-combined bus), except requestTransaction, which SHALL stay 1 from REQUEST through the end of RECEIVE.
REQ-028 In RECEIVE, each cycle with dataValidIn=1 SHALL produce, in the same cycle, memWriteEnable=1, memWriteData=addressDataIn and memAddress=current memory address.
REQ-029 After each valid beat, the memory address SHALL increment by 1 modulo 2^MEM_ADDR_WIDTH (wrap, no error).
REQ-030 After each valid beat, remaining SHALL decrement by 1.
REQ-031 Beats beyond the programmed burst length SHALL be discarded: no write, no count.
REQ-032 On endTransactionIn in RECEIVE, the bus address SHALL advance by 4 per beat received; the block SHALL go to REQUEST if remaining>0, else to FINISH.
REQ-033 dataValidIn and endTransactionIn asserted in the same cycle SHALL have the beat written before the end is evaluated.
REQ-034 busErrorIn in REQUEST, BEGIN or RECEIVE SHALL suppress any write that cycle, set error and go to FINISH.
REQ-035 FINISH SHALL last one cycle with done=1, busy=0 on exit, and SHALL return to IDLE.
REQ-036 error SHALL be cleared by the next accepted start.
REQ-037 The bus address SHALL wrap modulo 2^32.

Reset
REQ-038 While reset=0, the block SHALL be in IDLE with all outputs 0, including error, and all counters cleared.
REQ-039 Reset asserted mid-transfer SHALL abandon the transfer immediately, with no further memory writes and no done pulse.

Verification
REQ-040 The bench SHALL cover: blockSize=4, burstSize=15, bus 0x100, mem 0x010, grant after 3 cycles -> one burst with burstSizeOut=3 and writes to 0x010..0x013 with bus data; one done pulse.
REQ-041 The bench SHALL cover: blockSize=10, burstSize=3 -> bursts at 0x100, 0x110, 0x120 with burstSizeOut 3, 3, 1; ten writes; done after the third endTransactionIn.
REQ-042 The bench SHALL cover: mem 0x1FE, blockSize=4 -> writes to 0x1FE, 0x1FF, 0x000, 0x001.
REQ-043 The bench SHALL cover: busErrorIn on the 2nd beat -> one write only, error=1, done pulse, busy=0; the next start clears error.
REQ-044 The bench SHALL cover: blockSize=0 -> done one cycle later with requestTransaction never asserted; start while busy -> no effect on the running transfer.
REQ-045 The bench SHALL cover: reset=0 during RECEIVE -> all outputs 0 at once, no further writes, IDLE on release.
